// File: rtl/cpu_pkg.sv
// Shared core definitions: status bit positions, multiply-tracker state encoding
// and the condition codes evaluated by the ID condition-check stage.
package cpu_pkg;

    localparam int Z_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int V_BIT = 0;

    localparam int MUL_LAT_DEFAULT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_t;

    // Evaluates a condition code against a status nibble laid out {Z,C,N,V}.
    function automatic logic cond_pass(input cond_t cond, input logic [3:0] flags);
        logic z, c, n, v;
        z = flags[Z_BIT];
        c = flags[C_BIT];
        n = flags[N_BIT];
        v = flags[V_BIT];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/status_unit_if.sv
// Flag-update traffic between the EX/multiply pipeline and the status unit.
interface status_unit_if;

    logic       ex_valid;
    logic       ex_s_bit;
    logic [3:0] ex_flags;
    logic       mul_start;
    logic       mul_s_bit;
    logic [3:0] mul_flags;
    logic [3:0] status;
    logic [3:0] status_fwd;
    logic       flag_stall;
    logic       mul_busy;
    logic       conflict_err;

    modport master (
        output ex_valid, ex_s_bit, ex_flags, mul_start, mul_s_bit, mul_flags,
        input  status, status_fwd, flag_stall, mul_busy, conflict_err
    );

    modport slave (
        input  ex_valid, ex_s_bit, ex_flags, mul_start, mul_s_bit, mul_flags,
        output status, status_fwd, flag_stall, mul_busy, conflict_err
    );

endinterface

// File: rtl/status_fwd_mux.sv
// Priority bypass of the newest flags toward the condition-check stage.
// The EX instruction is younger than any multiply in flight, so it wins.
module status_fwd_mux (
    input  logic       ex_wr,
    input  logic [3:0] ex_flags,
    input  logic       mul_wr,
    input  logic [3:0] mul_flags,
    input  logic [3:0] status,
    output logic [3:0] status_fwd
);

    always_comb begin
        status_fwd = status;
        if (ex_wr) begin
            status_fwd = ex_flags;
        end else if (mul_wr) begin
            status_fwd = mul_flags;
        end
    end

endmodule

// File: rtl/status_unit.sv
// Architectural NZCV register with a tracker for the flag write of the
// multi-cycle multiplier, ID stall generation and flag forwarding.
module status_unit
    import cpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int CNT_W   = 4
) (
    input logic         clk,
    input logic         rst_n,
    status_unit_if.slave bus
);

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pend_s;
    logic [3:0]       status_q;
    logic             conflict_q;

    logic ex_wr;
    logic write_cycle;
    logic mul_wr;

    assign ex_wr       = bus.ex_valid && bus.ex_s_bit;
    assign write_cycle = (state == BUSY) && (cnt == '0);
    assign mul_wr      = write_cycle && pend_s;

    // A start arriving in the write cycle chains a new op while the old write commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_s     <= 1'b0;
            status_q   <= 4'b0000;
            conflict_q <= 1'b0;
        end else begin
            if (ex_wr) begin
                status_q <= bus.ex_flags;
            end else if (mul_wr) begin
                status_q <= bus.mul_flags;
            end

            if (ex_wr && mul_wr) begin
                conflict_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.mul_start) begin
                        state  <= BUSY;
                        cnt    <= CNT_W'(MUL_LAT - 1);
                        pend_s <= bus.mul_s_bit;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                        if (bus.mul_start) begin
                            conflict_q <= 1'b1;
                        end
                    end else if (bus.mul_start) begin
                        cnt    <= CNT_W'(MUL_LAT - 1);
                        pend_s <= bus.mul_s_bit;
                    end else begin
                        state  <= IDLE;
                        pend_s <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    pend_s <= 1'b0;
                end
            endcase
        end
    end

    status_fwd_mux u_fwd_mux (
        .ex_wr     (ex_wr),
        .ex_flags  (bus.ex_flags),
        .mul_wr    (mul_wr),
        .mul_flags (bus.mul_flags),
        .status    (status_q),
        .status_fwd(bus.status_fwd)
    );

    assign bus.status       = status_q;
    assign bus.mul_busy     = (state == BUSY);
    assign bus.flag_stall   = (state == BUSY) && pend_s && (cnt != '0);
    assign bus.conflict_err = conflict_q;

endmodule

// File: tb/tb_status_unit.sv
// Directed bench for status_unit: cycle-level behavioural model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_status_unit;

    localparam int MUL_LAT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic run   = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    status_unit_if bus ();

    status_unit #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model state: the multiply is described by the absolute cycle of its write.
    int         cyc      = 0;
    int         m_wr_cyc = -1;
    logic       m_pend   = 1'b0;
    logic [3:0] m_status = 4'b0000;
    logic       m_err    = 1'b0;

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ev, input logic es, input logic [3:0] ef,
                                 input logic ms, input logic mss, input logic [3:0] mf);
        @(posedge clk);
        #1;
        bus.ex_valid  = ev;
        bus.ex_s_bit  = es;
        bus.ex_flags  = ef;
        bus.mul_start = ms;
        bus.mul_s_bit = mss;
        bus.mul_flags = mf;
    endtask

    always @(negedge rst_n) begin
        m_wr_cyc = -1;
        m_pend   = 1'b0;
        m_status = 4'b0000;
        m_err    = 1'b0;
    end

    always @(posedge clk) begin
        logic ex_wr, in_wr, mul_wr, busy;
        if (!rst_n) begin
            m_wr_cyc = -1;
            m_pend   = 1'b0;
            m_status = 4'b0000;
            m_err    = 1'b0;
        end else begin
            ex_wr  = bus.ex_valid && bus.ex_s_bit;
            in_wr  = (m_wr_cyc == cyc);
            mul_wr = in_wr && m_pend;
            busy   = (m_wr_cyc >= cyc);
            if (ex_wr) m_status = bus.ex_flags;
            else if (mul_wr) m_status = bus.mul_flags;
            if (ex_wr && mul_wr) m_err = 1'b1;
            if (bus.mul_start) begin
                if (!busy || in_wr) begin
                    m_wr_cyc = cyc + MUL_LAT;
                    m_pend   = bus.mul_s_bit;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic       e_busy, e_stall;
        logic [3:0] e_fwd;
        if (run) begin
            e_busy  = (m_wr_cyc >= cyc);
            e_stall = e_busy && m_pend && (cyc < m_wr_cyc);
            if (bus.ex_valid && bus.ex_s_bit) e_fwd = bus.ex_flags;
            else if (m_wr_cyc == cyc && m_pend) e_fwd = bus.mul_flags;
            else e_fwd = m_status;
            checkOutput("model.status",       bus.status,             m_status);
            checkOutput("model.status_fwd",   bus.status_fwd,         e_fwd);
            checkOutput("model.mul_busy",     {3'b0, bus.mul_busy},     {3'b0, e_busy});
            checkOutput("model.flag_stall",   {3'b0, bus.flag_stall},   {3'b0, e_stall});
            checkOutput("model.conflict_err", {3'b0, bus.conflict_err}, {3'b0, m_err});
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.ex_valid  = 1'b0;
        bus.ex_s_bit  = 1'b0;
        bus.ex_flags  = 4'b0000;
        bus.mul_start = 1'b0;
        bus.mul_s_bit = 1'b0;
        bus.mul_flags = 4'b0000;
        @(posedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset / idle
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2;
        checkOutput("rst.status",     bus.status,     4'b0000);
        checkOutput("rst.status_fwd", bus.status_fwd, 4'b0000);
        checkOutput("rst.ctrl", {1'b0, bus.flag_stall, bus.mul_busy, bus.conflict_err}, 4'b0000);

        // EX flag write and non-writing EX op
        applyStimulus(1, 1, 4'b1000, 0, 0, 4'b0000);
        #2 checkOutput("ex.fwd", bus.status_fwd, 4'b1000);
        applyStimulus(1, 0, 4'b0111, 0, 0, 4'b0000);
        #2 checkOutput("ex.status", bus.status, 4'b1000);
        checkOutput("ex.nos_fwd", bus.status_fwd, 4'b1000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("ex.nos_status", bus.status, 4'b1000);

        // Flag-writing multiply
        applyStimulus(0, 0, 4'b0000, 1, 1, 4'b0110);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0110);
            #2;
            checkOutput("mul.busy",  {3'b0, bus.mul_busy},   4'b0001);
            checkOutput("mul.stall", {3'b0, bus.flag_stall}, (i < 3) ? 4'b0001 : 4'b0000);
        end
        checkOutput("mul.fwd_wc", bus.status_fwd, 4'b0110);
        checkOutput("mul.status_wc", bus.status, 4'b1000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("mul.status", bus.status, 4'b0110);
        checkOutput("mul.idle", {3'b0, bus.mul_busy}, 4'b0000);

        // Non-writing multiply
        applyStimulus(0, 0, 4'b0000, 1, 0, 4'b1111);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 4'b0000, 0, 0, 4'b1111);
            #2 checkOutput("mul0.busy_nostall", {2'b0, bus.mul_busy, bus.flag_stall}, 4'b0010);
        end
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("mul0.status", bus.status, 4'b0110);

        // EX write colliding with multiply write cycle
        applyStimulus(0, 0, 4'b0000, 1, 1, 4'b0100);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0100);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0100);
        applyStimulus(1, 1, 4'b0001, 0, 0, 4'b0100);
        #2 checkOutput("coll.fwd", bus.status_fwd, 4'b0001);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("coll.status", bus.status, 4'b0001);
        checkOutput("coll.err", {3'b0, bus.conflict_err}, 4'b0001);
        repeat (3) applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("coll.sticky", {3'b0, bus.conflict_err}, 4'b0001);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkOutput("coll.rst_clear", {3'b0, bus.conflict_err}, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Start accepted in the write cycle: chained op, no error
        applyStimulus(0, 0, 4'b0000, 1, 1, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 1, 1, 4'b1010);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("chain.status", bus.status, 4'b1010);
        checkOutput("chain.ctrl", {1'b0, bus.flag_stall, bus.mul_busy, bus.conflict_err}, 4'b0110);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0011);
        #2 checkOutput("chain.fwd_wc", bus.status_fwd, 4'b0011);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("chain.status2", bus.status, 4'b0011);
        checkOutput("chain.idle", {3'b0, bus.mul_busy}, 4'b0000);

        // Start while busy (not write cycle): ignored, error raised
        applyStimulus(0, 0, 4'b0000, 1, 1, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 1, 0, 4'b0000);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b1001);
        #2 checkOutput("ign.err", {3'b0, bus.conflict_err}, 4'b0001);
        checkOutput("ign.wc", {2'b0, bus.mul_busy, bus.flag_stall}, 4'b0010);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b0000);
        #2 checkOutput("ign.done", {3'b0, bus.mul_busy}, 4'b0000);
        checkOutput("ign.status", bus.status, 4'b1001);

        // Reset asserted mid-BUSY
        applyStimulus(0, 0, 4'b0000, 1, 1, 4'b1100);
        applyStimulus(0, 0, 4'b0000, 0, 0, 4'b1100);
        #1 rst_n = 1'b0;
        #1 checkOutput("midrst.busy", {3'b0, bus.mul_busy}, 4'b0000);
        checkOutput("midrst.status", bus.status, 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) applyStimulus(0, 0, 4'b0000, 0, 0, 4'b1100);
        #2 checkOutput("midrst.discard", bus.status, 4'b0000);

        @(posedge clk);
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
